// File: rtl/data_mem_responder.sv
// Load/store data-bus responder: word RAM behind a valid/ready request/response pair.
// Define DMEM_ERR_EN to report misaligned, out-of-range and undefined-funct3 accesses.
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int AW          = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [2:0]  REQ_FUNCT3,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        accept;
    logic        access;

    logic [31:0] mem_q [DEPTH];

    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic          sz_b, sz_h, uns, f3_bad;
    logic          err;
    logic [31:0]   load_val;
    logic [31:0]   wr_word;

    assign idx    = addr_q[AW+1:2];
    assign word   = mem_q[idx];
    assign lane_b = word[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h = word[{addr_q[1], 4'b0000} +: 16];

    // Undefined encodings fall back to a full-word access.
    always_comb begin
        sz_b   = 1'b0;
        sz_h   = 1'b0;
        uns    = 1'b0;
        f3_bad = 1'b0;
        case (f3_q)
            3'b000: sz_b = 1'b1;
            3'b001: sz_h = 1'b1;
            3'b010: ;
            3'b100: begin
                sz_b   = ~we_q;
                uns    = 1'b1;
                f3_bad = we_q;
            end
            3'b101: begin
                sz_h   = ~we_q;
                uns    = 1'b1;
                f3_bad = we_q;
            end
            default: f3_bad = 1'b1;
        endcase
    end

`ifdef DMEM_ERR_EN
    assign err = f3_bad
               | (sz_h & addr_q[0])
               | (~sz_b & ~sz_h & (addr_q[1:0] != 2'b00))
               | (addr_q[31:AW+2] != '0);
`else
    logic unused_bits;
    assign unused_bits = ^{addr_q[31:AW+2], f3_bad};
    assign err = 1'b0;
`endif

    always_comb begin
        load_val = word;
        if (sz_b) begin
            load_val = {{24{~uns & lane_b[7]}}, lane_b};
        end else if (sz_h) begin
            load_val = {{16{~uns & lane_h[15]}}, lane_h};
        end
    end

    always_comb begin
        wr_word = word;
        if (sz_b) begin
            wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (sz_h) begin
            wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            wr_word = wdata_q;
        end
    end

    // WAIT lasts WAIT_CYCLES+1 cycles; the RAM access happens on its last edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = RESP;
                    rdata_d = (we_q | err) ? 32'd0 : load_val;
                    err_d   = err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    state_d = IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= REQ_WE;
                f3_q    <= REQ_FUNCT3;
                addr_q  <= REQ_ADDR;
                wdata_q <= REQ_WDATA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (access && we_q && !err) begin
            mem_q[idx] <= wr_word;
        end
    end

    assign REQ_READY = (state_q == IDLE);
    assign RSP_VALID = (state_q == RESP);
    assign RSP_RDATA = rdata_q;
    assign RSP_ERR   = err_q;

endmodule
